// File: rtl/a2d_sequencer.sv
// a2d_sequencer
//   Runs one A2D conversion per nxt request through the SPI master, stepping
//   round-robin through left load cell, right load cell, steering pot and
//   battery. Each conversion is two SPI transactions: the first starts the
//   conversion on the selected channel, the second reads the result back.
//
// Ports
//   clk        : system clock
//   rst_n      : asynchronous active-low reset
//   nxt        : start conversion of the current round-robin channel
//   wrt        : one-clock pulse starting an SPI transaction (combinational)
//   cmd        : command word to the SPI master
//   done       : SPI transaction complete pulse
//   rd_data    : SPI read data, valid while done=1
//   lft_ld     : latest left load cell result
//   rght_ld    : latest right load cell result
//   steer_pot  : latest steering pot result
//   batt       : latest battery result
//   round_done : one-clock pulse after the battery result is stored
//   err        : one-clock pulse on SPI transaction timeout
module a2d_sequencer #(
    parameter logic [2:0]  CH_LFT     = 3'd0,
    parameter logic [2:0]  CH_RGHT    = 3'd4,
    parameter logic [2:0]  CH_STEER   = 3'd5,
    parameter logic [2:0]  CH_BATT    = 3'd6,
    parameter logic [15:0] TMO_CYCLES = 16'd4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        nxt,
    output logic        wrt,
    output logic [15:0] cmd,
    input  logic        done,
    input  logic [15:0] rd_data,
    output logic [11:0] lft_ld,
    output logic [11:0] rght_ld,
    output logic [11:0] steer_pot,
    output logic [11:0] batt,
    output logic        round_done,
    output logic        err
);

    typedef enum logic [1:0] {IDLE, CNV, READ} state_t;

    state_t      state_q, state_d;
    logic [1:0]  robin_q, robin_d;
    logic [15:0] tmo_cnt_q, tmo_cnt_d;
    logic        round_done_q, round_done_d;
    logic        err_q, err_d;
    logic [11:0] lft_ld_q, rght_ld_q, steer_pot_q, batt_q;
    logic        store;          // READ completed: capture into robin's register
    logic [2:0]  chnl;

    // Upper nibble of the SPI word carries no conversion data.
    logic [3:0]  unused_rd_hi;
    assign unused_rd_hi = rd_data[15:12];

    always_comb begin
        unique case (robin_q)
            2'd0:    chnl = CH_LFT;
            2'd1:    chnl = CH_RGHT;
            2'd2:    chnl = CH_STEER;
            default: chnl = CH_BATT;
        endcase
    end

    // robin only moves at the end of READ, so cmd holds for the whole conversion.
    assign cmd = {2'b00, chnl, 11'h000};

    always_comb begin
        state_d      = state_q;
        robin_d      = robin_q;
        tmo_cnt_d    = tmo_cnt_q;
        round_done_d = 1'b0;
        err_d        = 1'b0;
        wrt          = 1'b0;
        store        = 1'b0;
        unique case (state_q)
            IDLE: begin
                // done arriving here is stale and is deliberately ignored.
                if (nxt) begin
                    wrt       = 1'b1;
                    tmo_cnt_d = 16'd0;
                    state_d   = CNV;
                end
            end
            CNV: begin
                if (done) begin
                    // Read transaction launched back-to-back with conversion end.
                    wrt       = 1'b1;
                    tmo_cnt_d = 16'd0;
                    state_d   = READ;
                end else if (tmo_cnt_q == TMO_CYCLES - 16'd1) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 16'd1;
                end
            end
            READ: begin
                if (done) begin
                    store        = 1'b1;
                    robin_d      = robin_q + 2'd1;
                    round_done_d = (robin_q == 2'd3);
                    state_d      = IDLE;
                end else if (tmo_cnt_q == TMO_CYCLES - 16'd1) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            robin_q      <= 2'd0;
            tmo_cnt_q    <= 16'd0;
            round_done_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            robin_q      <= robin_d;
            tmo_cnt_q    <= tmo_cnt_d;
            round_done_q <= round_done_d;
            err_q        <= err_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lft_ld_q    <= 12'h000;
            rght_ld_q   <= 12'h000;
            steer_pot_q <= 12'h000;
            batt_q      <= 12'h000;
        end else if (store) begin
            unique case (robin_q)
                2'd0:    lft_ld_q    <= rd_data[11:0];
                2'd1:    rght_ld_q   <= rd_data[11:0];
                2'd2:    steer_pot_q <= rd_data[11:0];
                default: batt_q      <= rd_data[11:0];
            endcase
        end
    end

    assign lft_ld     = lft_ld_q;
    assign rght_ld    = rght_ld_q;
    assign steer_pot  = steer_pot_q;
    assign batt       = batt_q;
    assign round_done = round_done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_a2d_sequencer.sv
// tb_a2d_sequencer
//   Directed bench for a2d_sequencer: a default instance plus one built with
//   CH_LFT=1 and TMO_CYCLES=8. Inputs change 1ns after the rising edge; the
//   Mealy wrt is observed 1ns after that, registered outputs at edge+1ns.
module tb_a2d_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        nxt, done;
    logic [15:0] rd_data;
    logic        wrt, round_done, err;
    logic [15:0] cmd;
    logic [11:0] lft_ld, rght_ld, steer_pot, batt;

    logic        nxt2, done2;
    logic [15:0] rd_data2;
    logic        wrt2, round_done2, err2;
    logic [15:0] cmd2;
    logic [11:0] lft_ld2, rght_ld2, steer_pot2, batt2;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    always #5 clk = ~clk;

    a2d_sequencer dut (
        .clk(clk), .rst_n(rst_n), .nxt(nxt), .wrt(wrt), .cmd(cmd),
        .done(done), .rd_data(rd_data), .lft_ld(lft_ld), .rght_ld(rght_ld),
        .steer_pot(steer_pot), .batt(batt), .round_done(round_done), .err(err)
    );

    a2d_sequencer #(.CH_LFT(3'd1), .TMO_CYCLES(16'd8)) dut2 (
        .clk(clk), .rst_n(rst_n), .nxt(nxt2), .wrt(wrt2), .cmd(cmd2),
        .done(done2), .rd_data(rd_data2), .lft_ld(lft_ld2), .rght_ld(rght_ld2),
        .steer_pot(steer_pot2), .batt(batt2), .round_done(round_done2), .err(err2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_regs(input string tag, input logic [11:0] l, input logic [11:0] r,
                            input logic [11:0] s, input logic [11:0] b);
        chk({tag, ".lft_ld"}, 32'(lft_ld), 32'(l));
        chk({tag, ".rght_ld"}, 32'(rght_ld), 32'(r));
        chk({tag, ".steer_pot"}, 32'(steer_pot), 32'(s));
        chk({tag, ".batt"}, 32'(batt), 32'(b));
    endtask

    // One full conversion on dut; returns at edge+1ns of the first IDLE cycle
    // after the READ done, when the captured register must be visible.
    task automatic do_conv(input string tag, input logic [15:0] data,
                           input logic [15:0] exp_cmd, input logic hold_nxt);
        nxt = 1'b1; done = 1'b0;
        #1;
        chk({tag, ".wrt_cnv"}, 32'(wrt), 32'd1);
        chk({tag, ".cmd"}, 32'(cmd), 32'(exp_cmd));
        tick();
        nxt = hold_nxt;
        for (int i = 0; i < 2; i++) begin
            #1 chk({tag, ".wrt_idle_cnv"}, 32'(wrt), 32'd0);
            tick();
        end
        done = 1'b1;
        #1;
        chk({tag, ".wrt_read"}, 32'(wrt), 32'd1);
        chk({tag, ".cmd_read"}, 32'(cmd), 32'(exp_cmd));
        tick();
        done = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1 chk({tag, ".wrt_idle_read"}, 32'(wrt), 32'd0);
            tick();
        end
        done = 1'b1; rd_data = data;
        #1 chk({tag, ".wrt_done_read"}, 32'(wrt), 32'd0);
        tick();
        done = 1'b0; nxt = 1'b0; rd_data = 16'h0000;
    endtask

    initial begin
        rst_n = 1'b0; nxt = 1'b0; done = 1'b0; rd_data = 16'h0000;
        nxt2 = 1'b0; done2 = 1'b0; rd_data2 = 16'h0000;
        tick(); tick();

        // Reset state
        chk_regs("reset", 12'h000, 12'h000, 12'h000, 12'h000);
        chk("reset.round_done", 32'(round_done), 32'd0);
        chk("reset.err", 32'(err), 32'd0);
        chk("reset.wrt", 32'(wrt), 32'd0);
        chk("reset.cmd", 32'(cmd), 32'h0000);
        rst_n = 1'b1;
        tick();

        // Single conversion, upper nibble of rd_data discarded
        do_conv("conv1", 16'hF3A5, 16'h0000, 1'b0);
        chk_regs("conv1", 12'h3A5, 12'h000, 12'h000, 12'h000);
        chk("conv1.round_done", 32'(round_done), 32'd0);

        // Fresh round from robin=0
        rst_n = 1'b0;
        #1;
        chk_regs("rst2", 12'h000, 12'h000, 12'h000, 12'h000);
        tick();
        rst_n = 1'b1;
        tick();

        do_conv("rr0", 16'h0111, 16'h0000, 1'b0);
        chk("rr0.round_done", 32'(round_done), 32'd0);
        do_conv("rr1", 16'h0222, 16'h2000, 1'b0);
        chk("rr1.round_done", 32'(round_done), 32'd0);
        do_conv("rr2", 16'h0333, 16'h2800, 1'b0);
        chk("rr2.round_done", 32'(round_done), 32'd0);
        chk_regs("rr2", 12'h111, 12'h222, 12'h333, 12'h000);
        do_conv("rr3", 16'h0444, 16'h3000, 1'b0);
        chk("rr3.round_done", 32'(round_done), 32'd1);
        chk_regs("rr3", 12'h111, 12'h222, 12'h333, 12'h444);
        tick();
        chk("rr3.round_done_clear", 32'(round_done), 32'd0);

        // Fifth conversion wraps to left, with nxt held high throughout
        do_conv("rr4", 16'h0555, 16'h0000, 1'b1);
        chk_regs("rr4", 12'h555, 12'h222, 12'h333, 12'h444);
        chk("rr4.round_done", 32'(round_done), 32'd0);

        // nxt and done together in IDLE start a conversion (robin=1 now)
        nxt = 1'b1; done = 1'b1;
        #1 chk("both.wrt", 32'(wrt), 32'd1);
        tick();
        nxt = 1'b0;
        // done still high in CNV: ends the conversion transaction immediately
        #1 chk("both.wrt_cnv_done", 32'(wrt), 32'd1);
        tick();
        done = 1'b0;
        // READ timeout: 4096 clocks without done
        for (int i = 0; i < 4095; i++) tick();
        chk("tmo.err_before", 32'(err), 32'd0);
        chk("tmo.wrt_before", 32'(wrt), 32'd0);
        tick();
        chk("tmo.err", 32'(err), 32'd1);
        chk_regs("tmo", 12'h555, 12'h222, 12'h333, 12'h444);
        tick();
        chk("tmo.err_clear", 32'(err), 32'd0);

        // Same channel reconverted after timeout
        do_conv("retry", 16'h0ABC, 16'h2000, 1'b0);
        chk_regs("retry", 12'h555, 12'hABC, 12'h333, 12'h444);

        // Reset during READ (robin=2)
        nxt = 1'b1;
        #1 chk("rstmid.cmd", 32'(cmd), 32'h2800);
        tick();
        nxt = 1'b0; done = 1'b1;
        tick();
        done = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        chk_regs("rstmid", 12'h000, 12'h000, 12'h000, 12'h000);
        chk("rstmid.cmd0", 32'(cmd), 32'h0000);
        tick();
        rst_n = 1'b1;
        done = 1'b1; rd_data = 16'h0777;
        #1 chk("rstmid.wrt_done", 32'(wrt), 32'd0);
        tick();
        done = 1'b0;
        chk_regs("rstmid_after", 12'h000, 12'h000, 12'h000, 12'h000);
        chk("rstmid.wrt", 32'(wrt), 32'd0);
        chk("rstmid.round_done", 32'(round_done), 32'd0);
        chk("rstmid.err", 32'(err), 32'd0);

        // Overridden instance: CH_LFT=1, TMO_CYCLES=8
        nxt2 = 1'b1;
        #1;
        chk("ovr.wrt", 32'(wrt2), 32'd1);
        chk("ovr.cmd", 32'(cmd2), 32'h0800);
        tick();
        nxt2 = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        chk("ovr.err_before", 32'(err2), 32'd0);
        tick();
        chk("ovr.err", 32'(err2), 32'd1);
        chk("ovr.lft_ld", 32'(lft_ld2), 32'd0);
        tick();
        chk("ovr.err_clear", 32'(err2), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/a2d_sequencer.md
Name: a2d_sequencer

Overview:
- Upstream of the rider-detect/steer-enable logic; sits between the SPI master and the rest of the control path.
- On each `nxt` request it runs one conversion on the external A2D through the SPI master, as two SPI transactions.
- It cycles round-robin through four channels: left load cell, right load cell, steering pot and battery.
- Each result goes into a holding register. `lft_ld`/`rght_ld` feed the load-cell sum/difference logic directly.

Parameters:
CH_LFT, 3'd0, A2D channel for left load cell
CH_RGHT, 3'd4, A2D channel for right load cell
CH_STEER, 3'd5, A2D channel for steering pot
CH_BATT, 3'd6, A2D channel for battery
TMO_CYCLES, 16'd4096, clocks allowed per SPI transaction before abort

Ports:
clk  in  1  50MHz clock
rst_n  in  1  asynchronous active-low reset
nxt  in  1  request: start conversion of the current round-robin channel
wrt  out  1  one-clock pulse to SPI master starting a transaction
cmd  out  16  command to SPI master
done  in  1  one-clock pulse from SPI master: transaction complete
rd_data  in  16  SPI read data, valid while done=1
lft_ld  out  12  latest left load cell result
rght_ld  out  12  latest right load cell result
steer_pot  out  12  latest steering pot result
batt  out  12  latest battery result
round_done  out  1  one-clock pulse after the battery result is stored
err  out  1  one-clock pulse on transaction timeout

Behaviour:
- Clock and reset: clk; reset rst_n, asynchronous, active-low.
- Reset values: state=IDLE, robin=0, lft_ld=rght_ld=steer_pot=batt=12'h000, round_done=0, err=0, timeout counter=0.
- `wrt`: combinational (Mealy) output.
- `cmd`: {2'b00, chnl[2:0], 11'h000}.
  - chnl is selected by robin: 0→CH_LFT, 1→CH_RGHT, 2→CH_STEER, 3→CH_BATT.
  - cmd is stable from IDLE through READ.
- State IDLE:
  - If nxt=1: wrt=1 that cycle, clear timeout counter, go to CNV.
  - Otherwise stay; wrt=0.
- State CNV (conversion transaction in flight):
  - If done=1: wrt=1 that cycle (read transaction starts back-to-back), clear timeout counter, go to READ. rd_data is ignored.
  - Else if counter==TMO_CYCLES-1: go to IDLE and set err for one clock.
  - Otherwise increment the counter.
- State READ:
  - If done=1:
    - Capture rd_data[11:0] into the register selected by robin; it is visible on the next cycle.
    - robin increments and wraps 3→0.
    - If robin was 3, round_done=1 on the next cycle for one clock.
    - Go to IDLE.
  - Else timeout exactly as in CNV; on timeout no register updates and robin is unchanged.
- Register use: round_done and err are registered pulses. Only the register selected by robin changes per conversion; the others hold.
- Latency: nxt sampled in IDLE → wrt the same cycle. READ done edge → register updated one clock later.
- Boundary conditions:
  - nxt while in CNV/READ: ignored, not queued.
  - done while in IDLE: ignored.
  - nxt and done both high in IDLE: start a new conversion; done is ignored.
  - nxt in the cycle right after returning to IDLE: accepted.
  - Timeout counter: 16 bits; it never wraps, because timeout fires first.
  - Reset mid-transaction: immediate return to all reset values. The SPI master is reset by the same rst_n.
  - A2D data above 12 bits (rd_data[15:12]) is discarded.

Test Plan:
- Reset, then nxt pulse with CNV done and READ done (rd_data=16'hF3A5):
  - wrt pulses twice and cmd=16'h0000.
  - lft_ld=12'h3A5 one clock after the second done; other registers stay 0.
- Four consecutive conversions, rd_data = 12'h111, 12'h222, 12'h333, 12'h444:
  - cmd sequence 16'h0000, 16'h2000, 16'h2800, 16'h3000.
  - Registers lft_ld=111, rght_ld=222, steer_pot=333, batt=444.
  - round_done pulses exactly once, after the fourth; a fifth conversion goes to lft_ld.
- nxt held high throughout CNV and READ → exactly two wrt pulses per conversion; no extra transactions.
- done withheld in READ for TMO_CYCLES → err pulses once, state returns to IDLE, robin unchanged; the next nxt reconverts the same channel.
- rst_n asserted during READ with done arriving after reset release → no register update, robin=0, outputs all 0, wrt stays 0 until nxt.
- Overrides CH_LFT=3'd1, TMO_CYCLES=8 → first cmd=16'h0800; timeout after 8 idle clocks in CNV.
